lw_led_sw_responder: RTL and testbench



---
 rtl/lw_led_sw_pkg.sv | 27 ++
 rtl/lw_led_sw_if.sv | 22 ++
 rtl/lw_led_sw_debounce.sv | 61 ++++++
 rtl/lw_led_sw_responder.sv | 112 +++++++++++
 tb/tb_lw_led_sw_responder.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lw_led_sw_pkg.sv
// Shared constants, types and helpers for the LED/switch responder.
// Register addresses, default timing constants and a counter-width helper.
package lw_led_sw_pkg;

    localparam logic [2:0] ADDR_LED      = 3'd0;
    localparam logic [2:0] ADDR_SW_STATE = 3'd1;
    localparam logic [2:0] ADDR_SW_EDGE  = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_BLINK    = 3'd4;

    localparam int DEB_CYCLES_DEF = 500000;
    localparam int BLINK_DIV_DEF  = 12500000;

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } deb_state_t;

    // Bits needed to count 0..n-1 (minimum 1).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/lw_led_sw_if.sv
// Avalon-MM slave bus bundle (3-bit word address, 32-bit data,
// fixed read latency, no waitrequest).
interface lw_led_sw_if;

    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );

endinterface

// File: rtl/lw_led_sw_debounce.sv
// One switch bit: 2-flop synchroniser, stable/pending debounce counter.
// Ports: clk, reset, pin (raw), level (debounced), toggle (change event).
module sw_debounce
    import lw_led_sw_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic toggle
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    deb_state_t    st;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            st    <= ST_STABLE;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            unique case (st)
                ST_STABLE: begin
                    if (sync2 != level) begin
                        cnt <= cnt + 1'b1;
                        st  <= ST_PENDING;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_PENDING: begin
                    if (sync2 == level) begin
                        cnt <= '0;
                        st  <= ST_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        level <= ~level;
                        cnt   <= '0;
                        st    <= ST_STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Fires in the same cycle the debounced level flips.
    assign toggle = (st == ST_PENDING) && (sync2 != level) && (cnt == CNT_LAST);

endmodule

// File: rtl/lw_led_sw_responder.sv
// LED register, debounced switches, W1C edge capture and masked irq
// behind an Avalon-MM slave. Ports: clk, reset, avs (bus), irq, led_out,
// sw_in. Optional LED blinking is enabled by defining LW_LED_BLINK_EN.
module lw_led_sw_responder
    import lw_led_sw_pkg::*;
#(
    parameter int LED_W      = 8,
    parameter int SW_W       = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    lw_led_sw_if.slave       avs,
    output logic             irq,
    output logic [LED_W-1:0] led_out,
    input  logic [SW_W-1:0]  sw_in
);

    logic [LED_W-1:0] led_reg;
    logic [SW_W-1:0]  sw_state;
    logic [SW_W-1:0]  sw_toggle;
    logic [SW_W-1:0]  edge_reg;
    logic [SW_W-1:0]  mask_reg;
    logic [SW_W-1:0]  w1c;
    logic [31:0]      rdata;
    logic             wr_led;
    logic             wr_mask;
    logic             unused_wdata;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .pin    (sw_in[i]),
            .level  (sw_state[i]),
            .toggle (sw_toggle[i])
        );
    end

    assign wr_led  = avs.avs_write && (avs.avs_address == ADDR_LED);
    assign wr_mask = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
    assign w1c     = (avs.avs_write && (avs.avs_address == ADDR_SW_EDGE))
                   ? avs.avs_writedata[SW_W-1:0] : '0;
    assign unused_wdata = ^avs.avs_writedata[31:LED_W];

`ifdef LW_LED_BLINK_EN
    localparam int PW = cnt_width(BLINK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

    logic [LED_W-1:0] blink_reg;
    logic [PW-1:0]    pre;
    logic             phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_reg <= '0;
            pre       <= '0;
            phase     <= 1'b0;
        end else begin
            if (avs.avs_write && (avs.avs_address == ADDR_BLINK))
                blink_reg <= avs.avs_writedata[LED_W-1:0];
            if (pre == PRE_LAST) begin
                pre   <= '0;
                phase <= ~phase;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Phase starts at 0, so a blinking LED begins dark.
    assign led_out = led_reg & (~blink_reg | {LED_W{phase}});
`else
    localparam int unused_blink_div = BLINK_DIV;
    assign led_out = led_reg;
`endif

    always_comb begin
        rdata = '0;
        case (avs.avs_address)
            ADDR_LED:      rdata = 32'(led_reg);
            ADDR_SW_STATE: rdata = 32'(sw_state);
            ADDR_SW_EDGE:  rdata = 32'(edge_reg);
            ADDR_IRQ_MASK: rdata = 32'(mask_reg);
`ifdef LW_LED_BLINK_EN
            ADDR_BLINK:    rdata = 32'(blink_reg);
`endif
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg               <= '0;
            mask_reg              <= '0;
            edge_reg              <= '0;
            irq                   <= 1'b0;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            if (wr_led)  led_reg  <= avs.avs_writedata[LED_W-1:0];
            if (wr_mask) mask_reg <= avs.avs_writedata[SW_W-1:0];
            // A new edge overrides a same-cycle clear.
            edge_reg              <= (edge_reg & ~w1c) | sw_toggle;
            irq                   <= |(edge_reg & mask_reg);
            avs.avs_readdatavalid <= avs.avs_read;
            avs.avs_readdata      <= avs.avs_read ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_lw_led_sw_responder.sv
// Directed self-checking bench for lw_led_sw_responder
// (DEB_CYCLES=8, BLINK_DIV=4).
module tb_lw_led_sw_responder;

    logic       clk;
    logic       reset;
    logic       irq;
    logic [7:0] led_out;
    logic [3:0] sw_in;

    int pass_cnt;
    int total_cnt;

    lw_led_sw_if bus ();

    lw_led_sw_responder #(
        .LED_W(8), .SW_W(4), .DEB_CYCLES(8), .BLINK_DIV(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (bus),
        .irq     (irq),
        .led_out (led_out),
        .sw_in   (sw_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d,
                            output logic v);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
        v = bus.avs_readdatavalid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if (led_out !== 8'h00) $display("FAIL reset_led got %h want 00", led_out);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq);
        else pass_cnt++;
        total_cnt++;
        if (bus.avs_readdatavalid !== 1'b0)
            $display("FAIL reset_rdv got %b want 0", bus.avs_readdatavalid);
        else pass_cnt++;
        total_cnt++;
        if (bus.avs_readdata !== 32'h0)
            $display("FAIL reset_rdata got %h want 0", bus.avs_readdata);
        else pass_cnt++;
    endtask

    task automatic test_led();
        logic [31:0] d;
        logic v;
        bus_write(3'd0, 32'h0000_00A5);
        total_cnt++;
        if (led_out !== 8'hA5) $display("FAIL led_out got %h want a5", led_out);
        else pass_cnt++;
        bus_read(3'd0, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h0000_00A5)
            $display("FAIL led_read got %b/%h want 1/000000a5", v, d);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.avs_readdatavalid !== 1'b0)
            $display("FAIL rdv_pulse got %b want 0", bus.avs_readdatavalid);
        else pass_cnt++;
    endtask

    task automatic test_rw_same_cycle();
        @(negedge clk);
        bus.avs_address   = 3'd0;
        bus.avs_writedata = 32'h0000_003C;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        total_cnt++;
        if (bus.avs_readdata !== 32'h0000_00A5)
            $display("FAIL rw_pre_data got %h want 000000a5", bus.avs_readdata);
        else pass_cnt++;
        total_cnt++;
        if (led_out !== 8'h3C) $display("FAIL rw_led got %h want 3c", led_out);
        else pass_cnt++;
        bus_write(3'd0, 32'h0000_00A5);
    endtask

    task automatic test_reserved();
        logic [31:0] d;
        logic v;
        bus_read(3'd6, d, v);
        total_cnt++;
        if (v !== 1'b1 || d !== 32'h0)
            $display("FAIL rsvd_read got %b/%h want 1/0", v, d);
        else pass_cnt++;
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd0, d, v);
        total_cnt++;
        if (d !== 32'h0000_00A5) $display("FAIL rsvd_led got %h want a5", d);
        else pass_cnt++;
        bus_read(3'd3, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rsvd_mask got %h want 0", d);
        else pass_cnt++;
        bus_read(3'd2, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rsvd_edge got %h want 0", d);
        else pass_cnt++;
`ifndef LW_LED_BLINK_EN
        bus_write(3'd4, 32'h0000_00FF);
        bus_read(3'd4, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL addr4_rsvd got %h want 0", d);
        else pass_cnt++;
`endif
        total_cnt++;
        if (led_out !== 8'hA5) $display("FAIL rsvd_ledout got %h want a5", led_out);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic v;
        @(negedge clk);
        sw_in[2] = 1'b1;
        repeat (5) @(negedge clk);
        sw_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(3'd1, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch_state got %h want 0", d);
        else pass_cnt++;
        bus_read(3'd2, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch_edge got %h want 0", d);
        else pass_cnt++;
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        logic v;
        @(negedge clk);
        sw_in[0]        = 1'b1;
        bus.avs_address = 3'd1;
        bus.avs_read    = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) begin
                total_cnt++;
                if (bus.avs_readdata !== 32'h0)
                    $display("FAIL deb_early got %h want 0", bus.avs_readdata);
                else pass_cnt++;
            end
            if (k == 11) begin
                total_cnt++;
                if (bus.avs_readdata !== 32'h1)
                    $display("FAIL deb_state got %h want 1", bus.avs_readdata);
                else pass_cnt++;
            end
        end
        bus.avs_read = 1'b0;
        bus_read(3'd2, d, v);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL deb_edge got %h want 1", d);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL deb_irq_masked got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic v;
        bus_write(3'd2, 32'h1);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, d, v);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL mask_read got %h want 1", d);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq);
        else pass_cnt++;
        @(negedge clk);
        sw_in[0] = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) begin
                total_cnt++;
                if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq);
                else pass_cnt++;
            end
            if (k == 11) begin
                total_cnt++;
                if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq);
                else pass_cnt++;
            end
        end
        bus_write(3'd2, 32'h1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_w1c_lag got %b want 1", irq);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_w1c_clear got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        logic v;
        @(negedge clk);
        sw_in[0] = 1'b1;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL sw_irq_set got %b want 1", irq);
        else pass_cnt++;
        @(negedge clk);
        sw_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        bus_write(3'd2, 32'h1);
        @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL set_wins_irq got %b want 1", irq);
        else pass_cnt++;
        bus_read(3'd2, d, v);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL set_wins_edge got %h want 1", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic v;
        @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        sw_in = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (led_out !== 8'h00 || irq !== 1'b0)
            $display("FAIL mid_rst_out got %h/%b want 00/0", led_out, irq);
        else pass_cnt++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(3'd2, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_rst_edge got %h want 0", d);
        else pass_cnt++;
        bus_read(3'd1, d, v);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_rst_state got %h want 0", d);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL mid_rst_irq got %b want 0", irq);
        else pass_cnt++;
    endtask

`ifdef LW_LED_BLINK_EN
    task automatic test_blink();
        logic [31:0] d;
        logic v;
        logic [7:0] exp;
        int p;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_write(3'd0, 32'hFF);
        bus_write(3'd4, 32'h01);
        p = 4;
        for (int i = 0; i < 16; i++) begin
            exp = {7'h7F, ((p / 4) % 2) == 1};
            total_cnt++;
            if (led_out !== exp)
                $display("FAIL blink_p%0d got %h want %h", p, led_out, exp);
            else pass_cnt++;
            @(negedge clk);
            p++;
        end
        bus_read(3'd4, d, v);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL blink_read got %h want 1", d);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt              = 0;
        total_cnt             = 0;
        reset                 = 1'b1;
        sw_in                 = '0;
        bus.avs_address       = '0;
        bus.avs_read          = 1'b0;
        bus.avs_write         = 1'b0;
        bus.avs_writedata     = '0;
        test_reset();
        test_led();
        test_rw_same_cycle();
        test_reserved();
        test_glitch();
        test_debounce();
        test_irq();
        test_set_wins();
        test_reset_mid();
`ifdef LW_LED_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
